// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU data side (port 0)
// and a loader/debug master (port 1); IDLE -> ACCESS -> ACK, one transaction per 3 cycles.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [2:0]        m0_type,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [2:0]        m1_type,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              W_en,
    output logic              R_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [2:0]        RW_type,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  m0_cnt,
    output logic [CNT_W-1:0]  m1_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          type_q, type_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;
    logic                grant_s;

    // Next-state, arbitration and command capture
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        grant_s = 1'b0;

        // With both requesting, the port that did not win last time gets the grant
        if (m0_req && m1_req) begin
            grant_s = ~last_q;
        end else if (m1_req) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ACCESS;
                    last_d  = grant_s;
                    win_d   = grant_s;
                    we_d    = grant_s ? m1_we    : m0_we;
                    addr_d  = grant_s ? m1_addr  : m0_addr;
                    type_d  = grant_s ? m1_type  : m0_type;
                    wdata_d = grant_s ? m1_wdata : m0_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = dout;
                end else begin
                    rdata_d = rdata_q;
                end
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                state_d = ACK;
            end
            ACK: begin
                if (win_q) begin
                    cnt1_d = cnt1_q + CNT_W'(1);
                end else begin
                    cnt0_d = cnt0_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, command and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            type_q  <= 3'b000;
            wdata_q <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // Enables decode from state so the memory sees them in the ACCESS cycle itself
    assign W_en     = (state_q == ACCESS) &&  we_q;
    assign R_en     = (state_q == ACCESS) && !we_q;
    assign ram_addr = addr_q;
    assign RW_type  = type_q;
    assign din      = wdata_q;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;
    assign m0_cnt   = cnt0_q;
    assign m1_cnt   = cnt1_q;

endmodule
